// File: rtl/apb2axi_pkg.sv
// Shared types for the APB-to-AXI bridge: directory/completion records,
// default widths and the gateway completion-slice states.
package apb2axi_pkg;

   localparam int AXI_ADDR_W       = 32;
   localparam int TAG_W            = 4;
   localparam int GW_REQ_DEPTH_DEF = 4;

   typedef struct packed {
      logic [TAG_W-1:0]      tag;
      logic [AXI_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic                  is_write;
   } directory_entry_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             is_write;
      logic             error;
      logic [1:0]       resp;
      logic [7:0]       num_beats;
   } completion_entry_t;

   localparam int COMPLETION_W = $bits(completion_entry_t);

   typedef enum logic {
      GW_CPL_EMPTY,
      GW_CPL_HELD
   } gw_cpl_state_e;

endpackage

// File: rtl/apb2axi_gw_req_fifo.sv
// Synchronous request FIFO for the gateway; DEPTH must be a power of two so
// the pointers wrap naturally.
module apb2axi_gw_req_fifo
   import apb2axi_pkg::*;
#(
   parameter int DEPTH = GW_REQ_DEPTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  directory_entry_t data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output directory_entry_t head_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   directory_entry_t mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/apb2axi_gateway_v2.sv
// PCLK-domain request/completion hub: request FIFO, tag-throttled allocation,
// two-way completion fork. Optional statistics under APB2AXI_GW_STATS_EN.
module apb2axi_gateway_v2 #(
   parameter int AXI_ADDR_W      = apb2axi_pkg::AXI_ADDR_W,
   parameter int TAG_W           = apb2axi_pkg::TAG_W,
   parameter int COMPLETION_W    = apb2axi_pkg::COMPLETION_W,
   parameter int REQ_DEPTH       = apb2axi_pkg::GW_REQ_DEPTH_DEF,
   parameter int MAX_OUTSTANDING = 2**TAG_W,
   parameter int STAT_W          = 16
) (
   input  logic                                   pclk,
   input  logic                                   preset,
   input  logic                                   commit_pulse,
   input  logic [AXI_ADDR_W-1:0]                  addr,
   input  logic [7:0]                             len,
   input  logic [2:0]                             size,
   input  logic                                   is_write,
   output logic                                   req_full,
   output logic                                   req_overflow,
   input  logic                                   req_ovf_clr,
   output apb2axi_pkg::directory_entry_t          dir_alloc_entry,
   output logic                                   dir_alloc_valid,
   input  logic                                   dir_alloc_ready,
   input  logic [TAG_W-1:0]                       dir_alloc_tag,
   output logic                                   alloc_tag_valid,
   output logic [TAG_W-1:0]                       alloc_tag,
   input  logic                                   gw_cpl_valid,
   output logic                                   gw_cpl_ready,
   input  logic [COMPLETION_W-1:0]                gw_cpl_data,
   output logic                                   dir_cpl_valid,
   input  logic                                   dir_cpl_ready,
   output logic                                   rd_status_valid,
   input  logic                                   rd_status_ready,
   output logic [TAG_W-1:0]                       dir_cpl_tag,
   output logic                                   dir_cpl_is_write,
   output logic                                   dir_cpl_error,
   output logic [1:0]                             dir_cpl_resp,
   output logic [7:0]                             dir_cpl_num_beats,
   output logic [TAG_W-1:0]                       rd_status_tag,
   output logic                                   rd_status_is_write,
   output logic                                   rd_status_error,
   output logic [1:0]                             rd_status_resp,
   output logic [7:0]                             rd_status_num_beats,
   input  logic                                   dir_cons_valid,
   input  logic [TAG_W-1:0]                       dir_cons_tag,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
`ifdef APB2AXI_GW_STATS_EN
   ,
   output logic [STAT_W-1:0]                      stat_alloc_cnt,
   output logic [STAT_W-1:0]                      stat_cpl_cnt,
   output logic [STAT_W-1:0]                      stat_err_cnt
`endif
);

   import apb2axi_pkg::*;

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + STAT_W'(1) : v;
   endfunction

   directory_entry_t  push_entry, head_entry;
   completion_entry_t gw_entry, cpl_q, cpl_d;
   gw_cpl_state_e     state_q, state_d;
   logic              fifo_full, fifo_empty, push, alloc_hs;
   logic              ovf_q, ovf_d, atv_q;
   logic [TAG_W-1:0]  atag_q, atag_d;
   logic [OUT_W-1:0]  out_q, out_d;
   logic              dsent_q, dsent_d, rsent_q, rsent_d;
   logic              dir_hs, rd_hs, done, cap;
   logic              unused_cons_tag;

   assign unused_cons_tag = ^dir_cons_tag;

   always_comb begin
      push_entry          = '0;
      push_entry.addr     = addr;
      push_entry.len      = len;
      push_entry.size     = size;
      push_entry.is_write = is_write;
   end

   // Fullness is registered, so a commit on a full FIFO is lost even if a pop
   // frees a slot in the same cycle.
   assign push = commit_pulse && !fifo_full;

   apb2axi_gw_req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
      .clk_i   (pclk),
      .rst_i   (preset),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (alloc_hs),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head_entry)
   );

   assign req_full        = fifo_full;
   assign req_overflow    = ovf_q;
   assign dir_alloc_valid = !fifo_empty && (out_q < OUT_W'(MAX_OUTSTANDING));
   assign dir_alloc_entry = fifo_empty ? '0 : head_entry;
   assign alloc_hs        = dir_alloc_valid && dir_alloc_ready;
   assign alloc_tag_valid = atv_q;
   assign alloc_tag       = atag_q;
   assign outstanding     = out_q;

   always_comb begin
      ovf_d  = ovf_q;
      atag_d = atag_q;
      out_d  = out_q;
      if (commit_pulse && fifo_full) ovf_d = 1'b1;
      else if (req_ovf_clr)          ovf_d = 1'b0;
      if (alloc_hs) atag_d = dir_alloc_tag;
      unique case ({alloc_hs, dir_cons_valid && (out_q != '0)})
         2'b10:   out_d = out_q + OUT_W'(1);
         2'b01:   out_d = out_q - OUT_W'(1);
         default: out_d = out_q;
      endcase
   end

   assign gw_entry = completion_entry_t'(gw_cpl_data);

   // Each destination is released independently; the slice frees (or reloads)
   // only once both have taken the held completion.
   always_comb begin
      state_d         = state_q;
      cpl_d           = cpl_q;
      dir_cpl_valid   = 1'b0;
      rd_status_valid = 1'b0;
      if (state_q == GW_CPL_HELD) begin
         dir_cpl_valid   = !dsent_q;
         rd_status_valid = !rsent_q;
      end
      dir_hs       = dir_cpl_valid && dir_cpl_ready;
      rd_hs        = rd_status_valid && rd_status_ready;
      done         = (state_q == GW_CPL_HELD) && (dsent_q || dir_hs) && (rsent_q || rd_hs);
      gw_cpl_ready = (state_q == GW_CPL_EMPTY) || done;
      cap          = gw_cpl_valid && gw_cpl_ready;
      dsent_d      = dsent_q || dir_hs;
      rsent_d      = rsent_q || rd_hs;
      if (cap) begin
         cpl_d   = gw_entry;
         dsent_d = 1'b0;
         rsent_d = 1'b0;
         state_d = GW_CPL_HELD;
      end else if (done) begin
         state_d = GW_CPL_EMPTY;
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         ovf_q   <= 1'b0;
         atv_q   <= 1'b0;
         atag_q  <= '0;
         out_q   <= '0;
         state_q <= GW_CPL_EMPTY;
         cpl_q   <= '0;
         dsent_q <= 1'b0;
         rsent_q <= 1'b0;
      end else begin
         ovf_q   <= ovf_d;
         atv_q   <= alloc_hs;
         atag_q  <= atag_d;
         out_q   <= out_d;
         state_q <= state_d;
         cpl_q   <= cpl_d;
         dsent_q <= dsent_d;
         rsent_q <= rsent_d;
      end
   end

   assign dir_cpl_tag         = cpl_q.tag;
   assign dir_cpl_is_write    = cpl_q.is_write;
   assign dir_cpl_error       = cpl_q.error;
   assign dir_cpl_resp        = cpl_q.resp;
   assign dir_cpl_num_beats   = cpl_q.num_beats;
   assign rd_status_tag       = cpl_q.tag;
   assign rd_status_is_write  = cpl_q.is_write;
   assign rd_status_error     = cpl_q.error;
   assign rd_status_resp      = cpl_q.resp;
   assign rd_status_num_beats = cpl_q.num_beats;

`ifdef APB2AXI_GW_STATS_EN
   logic [STAT_W-1:0] st_alloc_q, st_cpl_q, st_err_q;

   always_ff @(posedge pclk) begin
      if (preset) begin
         st_alloc_q <= '0;
         st_cpl_q   <= '0;
         st_err_q   <= '0;
      end else begin
         st_alloc_q <= sat_inc(st_alloc_q, alloc_hs);
         st_cpl_q   <= sat_inc(st_cpl_q, cap);
         st_err_q   <= sat_inc(st_err_q, cap && gw_entry.error);
      end
   end

   assign stat_alloc_cnt = st_alloc_q;
   assign stat_cpl_cnt   = st_cpl_q;
   assign stat_err_cnt   = st_err_q;
`endif

endmodule

// File: tb/tb_apb2axi_gateway_v2.sv
// Bench for apb2axi_gateway_v2: vector table for the request path, directed
// completion sequences, then randomized traffic against a queue-based model.
module tb_apb2axi_gateway_v2;
   import apb2axi_pkg::*;

   localparam int DEPTH = 4;
   localparam int MAXO  = 2;
   localparam int OUT_W = $clog2(MAXO + 1);

   logic pclk, preset, commit_pulse, is_write, req_full, req_overflow, req_ovf_clr;
   logic [31:0] addr;
   logic [7:0]  len;
   logic [2:0]  size;
   directory_entry_t dir_alloc_entry;
   logic dir_alloc_valid, dir_alloc_ready, alloc_tag_valid;
   logic [3:0] dir_alloc_tag, alloc_tag, dir_cons_tag;
   logic gw_cpl_valid, gw_cpl_ready, dir_cpl_valid, dir_cpl_ready, rd_status_valid, rd_status_ready;
   logic [15:0] gw_cpl_data;
   logic [3:0] dir_cpl_tag, rd_status_tag;
   logic dir_cpl_is_write, dir_cpl_error, rd_status_is_write, rd_status_error;
   logic [1:0] dir_cpl_resp, rd_status_resp;
   logic [7:0] dir_cpl_num_beats, rd_status_num_beats;
   logic dir_cons_valid;
   logic [OUT_W-1:0] outstanding;
`ifdef APB2AXI_GW_STATS_EN
   logic [15:0] stat_alloc_cnt, stat_cpl_cnt, stat_err_cnt;
`endif

   apb2axi_gateway_v2 #(.REQ_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .pclk(pclk), .preset(preset), .commit_pulse(commit_pulse), .addr(addr), .len(len),
      .size(size), .is_write(is_write), .req_full(req_full), .req_overflow(req_overflow),
      .req_ovf_clr(req_ovf_clr), .dir_alloc_entry(dir_alloc_entry),
      .dir_alloc_valid(dir_alloc_valid), .dir_alloc_ready(dir_alloc_ready),
      .dir_alloc_tag(dir_alloc_tag), .alloc_tag_valid(alloc_tag_valid), .alloc_tag(alloc_tag),
      .gw_cpl_valid(gw_cpl_valid), .gw_cpl_ready(gw_cpl_ready), .gw_cpl_data(gw_cpl_data),
      .dir_cpl_valid(dir_cpl_valid), .dir_cpl_ready(dir_cpl_ready),
      .rd_status_valid(rd_status_valid), .rd_status_ready(rd_status_ready),
      .dir_cpl_tag(dir_cpl_tag), .dir_cpl_is_write(dir_cpl_is_write), .dir_cpl_error(dir_cpl_error),
      .dir_cpl_resp(dir_cpl_resp), .dir_cpl_num_beats(dir_cpl_num_beats),
      .rd_status_tag(rd_status_tag), .rd_status_is_write(rd_status_is_write),
      .rd_status_error(rd_status_error), .rd_status_resp(rd_status_resp),
      .rd_status_num_beats(rd_status_num_beats), .dir_cons_valid(dir_cons_valid),
      .dir_cons_tag(dir_cons_tag), .outstanding(outstanding)
`ifdef APB2AXI_GW_STATS_EN
      , .stat_alloc_cnt(stat_alloc_cnt), .stat_cpl_cnt(stat_cpl_cnt), .stat_err_cnt(stat_err_cnt)
`endif
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic idle();
      commit_pulse = 0; addr = 0; len = 0; size = 0; is_write = 0; req_ovf_clr = 0;
      dir_alloc_ready = 0; dir_alloc_tag = 0; gw_cpl_valid = 0; gw_cpl_data = 0;
      dir_cpl_ready = 0; rd_status_ready = 0; dir_cons_valid = 0; dir_cons_tag = 0;
   endtask

   function automatic logic [15:0] cpl(input logic [3:0] t, input logic w, input logic e,
                                       input logic [1:0] r, input logic [7:0] b);
      completion_entry_t c;
      c.tag = t; c.is_write = w; c.error = e; c.resp = r; c.num_beats = b;
      return 16'(c);
   endfunction

   typedef struct {
      logic        commit;
      logic [31:0] a;
      logic [7:0]  l;
      logic        rdy;
      logic [3:0]  tg;
      logic        cons;
      logic        clr;
      logic        e_full, e_ovf, e_valid, e_atv;
      logic [3:0]  e_atag;
      int          e_out;
      logic [31:0] e_head;
      logic [7:0]  e_len;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic c, input logic [31:0] a, input logic [7:0] l,
                               input logic r, input logic [3:0] tg, input logic cn, input logic cl,
                               input logic f, input logic o, input logic v, input logic atv,
                               input logic [3:0] at, input int ou, input logic [31:0] h,
                               input logic [7:0] hl);
      vec_t x;
      x.commit = c; x.a = a; x.l = l; x.rdy = r; x.tg = tg; x.cons = cn; x.clr = cl;
      x.e_full = f; x.e_ovf = o; x.e_valid = v; x.e_atv = atv; x.e_atag = at; x.e_out = ou;
      x.e_head = h; x.e_len = hl;
      return x;
   endfunction

   // reference model state
   directory_entry_t  mq[$];
   completion_entry_t mheld;
   int   mout, m_alloc, m_cpl, m_err;
   bit   movf, matv, mhas, mdsent, mrsent;
   logic [3:0] matag;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
      $fatal(1);
   end

   initial begin
      idle();
      preset = 1;
      tick(); tick();
      preset = 0;

      chk("rst.req_full", req_full, 0);
      chk("rst.req_overflow", req_overflow, 0);
      chk("rst.dir_alloc_valid", dir_alloc_valid, 0);
      chk("rst.dir_alloc_entry", dir_alloc_entry, 0);
      chk("rst.alloc_tag_valid", alloc_tag_valid, 0);
      chk("rst.alloc_tag", alloc_tag, 0);
      chk("rst.outstanding", outstanding, 0);
      chk("rst.dir_cpl_valid", dir_cpl_valid, 0);
      chk("rst.rd_status_valid", rd_status_valid, 0);
      chk("rst.dir_cpl_tag", dir_cpl_tag, 0);

      //        cm addr      len rdy tg cns clr | full ovf vld atv atag out head      hlen
      tbl.push_back(mk(1, 32'h100,  1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 32'h100,  1));
      tbl.push_back(mk(1, 32'h104,  2, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 32'h100,  1));
      tbl.push_back(mk(1, 32'h108,  3, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 32'h100,  1));
      tbl.push_back(mk(1, 32'h10C,  4, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 32'h100,  1));
      tbl.push_back(mk(1, 32'h110,  5, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 32'h100,  1));
      tbl.push_back(mk(0, 0,        0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 32'h100,  1));
      tbl.push_back(mk(1, 32'h114,  6, 0, 0, 0, 1,   1, 1, 1, 0, 0, 0, 32'h100,  1));
      tbl.push_back(mk(0, 0,        0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 32'h100,  1));
      tbl.push_back(mk(0, 0,        0, 1, 5, 0, 0,   0, 0, 1, 1, 5, 1, 32'h104,  2));
      tbl.push_back(mk(0, 0,        0, 1, 6, 0, 0,   0, 0, 0, 1, 6, 2, 0,        0));
      tbl.push_back(mk(0, 0,        0, 1, 7, 0, 0,   0, 0, 0, 0, 6, 2, 0,        0));
      tbl.push_back(mk(0, 0,        0, 1, 7, 1, 0,   0, 0, 1, 0, 6, 1, 32'h108,  3));
      tbl.push_back(mk(0, 0,        0, 1, 7, 0, 0,   0, 0, 0, 1, 7, 2, 0,        0));
      tbl.push_back(mk(0, 0,        0, 1, 8, 1, 0,   0, 0, 1, 0, 7, 1, 32'h10C,  4));
      tbl.push_back(mk(0, 0,        0, 1, 8, 1, 0,   0, 0, 0, 1, 8, 1, 0,        0));
      tbl.push_back(mk(0, 0,        0, 0, 0, 1, 0,   0, 0, 0, 0, 8, 0, 0,        0));
      tbl.push_back(mk(0, 0,        0, 0, 0, 1, 0,   0, 0, 0, 0, 8, 0, 0,        0));
      tbl.push_back(mk(1, 32'h1000, 3, 1, 5, 0, 0,   0, 0, 1, 0, 8, 0, 32'h1000, 3));
      tbl.push_back(mk(0, 0,        0, 1, 5, 0, 0,   0, 0, 0, 1, 5, 1, 0,        0));
      tbl.push_back(mk(0, 0,        0, 0, 0, 0, 0,   0, 0, 0, 0, 5, 1, 0,        0));

      for (int i = 0; i < tbl.size(); i++) begin
         commit_pulse = tbl[i].commit; addr = tbl[i].a; len = tbl[i].l;
         dir_alloc_ready = tbl[i].rdy; dir_alloc_tag = tbl[i].tg;
         dir_cons_valid = tbl[i].cons; req_ovf_clr = tbl[i].clr;
         tick();
         chk($sformatf("tbl%0d.req_full", i), req_full, tbl[i].e_full);
         chk($sformatf("tbl%0d.req_overflow", i), req_overflow, tbl[i].e_ovf);
         chk($sformatf("tbl%0d.dir_alloc_valid", i), dir_alloc_valid, tbl[i].e_valid);
         chk($sformatf("tbl%0d.alloc_tag_valid", i), alloc_tag_valid, tbl[i].e_atv);
         chk($sformatf("tbl%0d.alloc_tag", i), alloc_tag, tbl[i].e_atag);
         chk($sformatf("tbl%0d.outstanding", i), outstanding, tbl[i].e_out);
         if (tbl[i].e_valid) begin
            chk($sformatf("tbl%0d.head_addr", i), dir_alloc_entry.addr, tbl[i].e_head);
            chk($sformatf("tbl%0d.head_len", i), dir_alloc_entry.len, tbl[i].e_len);
            chk($sformatf("tbl%0d.head_tag", i), dir_alloc_entry.tag, 0);
         end
      end
      idle();

      // completion held while the regfile stalls
      gw_cpl_valid = 1; gw_cpl_data = cpl(3, 1, 0, 2'b00, 4);
      dir_cpl_ready = 1; rd_status_ready = 0;
      #1 chk("cplA.ready_empty", gw_cpl_ready, 1);
      tick();
      gw_cpl_data = cpl(9, 0, 1, 2'b10, 7);
      #1;
      chk("cplA.c1.dir_valid", dir_cpl_valid, 1);
      chk("cplA.c1.rd_valid", rd_status_valid, 1);
      chk("cplA.c1.dir_tag", dir_cpl_tag, 3);
      chk("cplA.c1.ready", gw_cpl_ready, 0);
      tick();
      chk("cplA.c2.dir_valid", dir_cpl_valid, 0);
      chk("cplA.c2.rd_valid", rd_status_valid, 1);
      chk("cplA.c2.rd_tag", rd_status_tag, 3);
      chk("cplA.c2.ready", gw_cpl_ready, 0);
      tick();
      chk("cplA.c3.dir_valid", dir_cpl_valid, 0);
      chk("cplA.c3.rd_valid", rd_status_valid, 1);
      chk("cplA.c3.ready", gw_cpl_ready, 0);
      rd_status_ready = 1;
      #1 chk("cplA.c3.ready_comb", gw_cpl_ready, 1);
      tick();
      chk("cplA.reload.dir_valid", dir_cpl_valid, 1);
      chk("cplA.reload.dir_tag", dir_cpl_tag, 9);
      chk("cplA.reload.rd_error", rd_status_error, 1);
      chk("cplA.reload.rd_resp", rd_status_resp, 2'b10);
      gw_cpl_valid = 0;
      tick();
      chk("cplA.end.dir_valid", dir_cpl_valid, 0);
      chk("cplA.end.rd_valid", rd_status_valid, 0);
      chk("cplA.end.ready", gw_cpl_ready, 1);

      // eight back-to-back completions
      for (int k = 0; k < 8; k++) begin
         gw_cpl_valid = 1; gw_cpl_data = cpl(4'(k), k[0], (k == 5), 2'(k), 8'(k + 1));
         #1 chk($sformatf("cplB%0d.ready", k), gw_cpl_ready, 1);
         tick();
         chk($sformatf("cplB%0d.dir_valid", k), dir_cpl_valid, 1);
         chk($sformatf("cplB%0d.rd_valid", k), rd_status_valid, 1);
         chk($sformatf("cplB%0d.dir_tag", k), dir_cpl_tag, k);
         chk($sformatf("cplB%0d.rd_beats", k), rd_status_num_beats, k + 1);
         chk($sformatf("cplB%0d.dir_error", k), dir_cpl_error, (k == 5));
      end
      gw_cpl_valid = 0;
      tick();
      chk("cplB.end.dir_valid", dir_cpl_valid, 0);
`ifdef APB2AXI_GW_STATS_EN
      chk("stats.alloc", stat_alloc_cnt, 5);
      chk("stats.cpl", stat_cpl_cnt, 10);
      chk("stats.err", stat_err_cnt, 2);
`endif

      // reset in the middle of traffic
      commit_pulse = 1; addr = 32'h2000;
      tick(); tick();
      commit_pulse = 0;
      gw_cpl_valid = 1; gw_cpl_data = cpl(6, 1, 1, 2'b11, 2);
      tick();
      gw_cpl_valid = 0;
      chk("rstmid.pre.dir_valid", dir_cpl_valid, 1);
      chk("rstmid.pre.alloc_valid", dir_alloc_valid, 1);
      preset = 1;
      tick();
      chk("rstmid.dir_valid", dir_cpl_valid, 0);
      chk("rstmid.rd_valid", rd_status_valid, 0);
      chk("rstmid.alloc_valid", dir_alloc_valid, 0);
      chk("rstmid.outstanding", outstanding, 0);
      chk("rstmid.req_full", req_full, 0);
      chk("rstmid.dir_tag", dir_cpl_tag, 0);
`ifdef APB2AXI_GW_STATS_EN
      chk("rstmid.stat_cpl", stat_cpl_cnt, 0);
`endif
      preset = 0;

      // randomized traffic against the behavioural model
      mq.delete(); mheld = '0; mout = 0; movf = 0; matv = 0; matag = 0;
      mhas = 0; mdsent = 0; mrsent = 0; m_alloc = 0; m_cpl = 0; m_err = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         bit e_valid, dv, rv, dh, rh, dn, rdy, mfull, cap, al, dec;
         directory_entry_t ne;
         commit_pulse    = ($urandom_range(0, 99) < 50);
         addr            = $urandom;
         len             = 8'($urandom);
         size            = 3'($urandom);
         is_write        = 1'($urandom);
         req_ovf_clr     = ($urandom_range(0, 99) < 10);
         dir_alloc_ready = ($urandom_range(0, 99) < 50);
         dir_alloc_tag   = 4'($urandom);
         dir_cons_valid  = ($urandom_range(0, 99) < 30);
         dir_cons_tag    = 4'($urandom);
         gw_cpl_valid    = ($urandom_range(0, 99) < 60);
         gw_cpl_data     = 16'($urandom);
         dir_cpl_ready   = ($urandom_range(0, 99) < 60);
         rd_status_ready = ($urandom_range(0, 99) < 60);
         #2;
         mfull   = (mq.size() == DEPTH);
         e_valid = (mq.size() > 0) && (mout < MAXO);
         dv = mhas && !mdsent;
         rv = mhas && !mrsent;
         dh = dv && dir_cpl_ready;
         rh = rv && rd_status_ready;
         dn = mhas && (mdsent || dh) && (mrsent || rh);
         rdy = !mhas || dn;
         chk($sformatf("rnd%0d.req_full", cyc), req_full, mfull);
         chk($sformatf("rnd%0d.req_overflow", cyc), req_overflow, movf);
         chk($sformatf("rnd%0d.dir_alloc_valid", cyc), dir_alloc_valid, e_valid);
         if (e_valid) chk($sformatf("rnd%0d.head", cyc), dir_alloc_entry, mq[0]);
         chk($sformatf("rnd%0d.alloc_tag_valid", cyc), alloc_tag_valid, matv);
         chk($sformatf("rnd%0d.alloc_tag", cyc), alloc_tag, matag);
         chk($sformatf("rnd%0d.outstanding", cyc), outstanding, mout);
         chk($sformatf("rnd%0d.dir_cpl_valid", cyc), dir_cpl_valid, dv);
         chk($sformatf("rnd%0d.rd_status_valid", cyc), rd_status_valid, rv);
         chk($sformatf("rnd%0d.gw_cpl_ready", cyc), gw_cpl_ready, rdy);
         chk($sformatf("rnd%0d.dir_fields", cyc),
             {dir_cpl_tag, dir_cpl_is_write, dir_cpl_error, dir_cpl_resp, dir_cpl_num_beats}, mheld);
         chk($sformatf("rnd%0d.rd_fields", cyc),
             {rd_status_tag, rd_status_is_write, rd_status_error, rd_status_resp, rd_status_num_beats}, mheld);

         al  = e_valid && dir_alloc_ready;
         dec = dir_cons_valid && (mout > 0);
         if (commit_pulse && mfull) movf = 1;
         else if (req_ovf_clr)      movf = 0;
         matv = al;
         if (al) begin
            void'(mq.pop_front());
            matag = dir_alloc_tag;
            m_alloc++;
         end
         if (commit_pulse && !mfull) begin
            ne = '0; ne.addr = addr; ne.len = len; ne.size = size; ne.is_write = is_write;
            mq.push_back(ne);
         end
         mout = mout + (al ? 1 : 0) - (dec ? 1 : 0);
         cap = gw_cpl_valid && rdy;
         if (cap) begin
            mheld = completion_entry_t'(gw_cpl_data);
            mhas = 1; mdsent = 0; mrsent = 0;
            m_cpl++;
            if (mheld.error) m_err++;
         end else if (dn) begin
            mhas = 0;
         end else begin
            mdsent = mdsent || dh;
            mrsent = mrsent || rh;
         end
         @(posedge pclk);
         #1;
      end
`ifdef APB2AXI_GW_STATS_EN
      chk("rnd.stat_alloc", stat_alloc_cnt, m_alloc);
      chk("rnd.stat_cpl", stat_cpl_cnt, m_cpl);
      chk("rnd.stat_err", stat_err_cnt, m_err);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/apb2axi_gateway_v2.md
# apb2axi_gateway_v2

Next-generation PCLK-domain request/completion hub between the APB regfile, the tag directory and the AXI response handler. Buffers APB commits in a parametrised request FIFO, throttles directory allocation against an outstanding-tag limit, returns the allocated TAG to the regfile, and delivers each completion to directory and regfile through an independent two-way fork handshake with a one-entry register slice.

## Interface
- AXI_ADDR_W, pkg AXI_ADDR_W, request address width
- TAG_W, pkg TAG_W, tag width
- COMPLETION_W, pkg COMPLETION_W, packed completion_entry_t width
- REQ_DEPTH, 4, request FIFO depth; power of two, ≥2
- MAX_OUTSTANDING, 2**TAG_W, allocation limit
- STAT_W, 16, statistics counter width
- pclk  in  1  clock
- preset  in  1  synchronous, active-high reset
- commit_pulse  in  1  regfile commit strobe
- addr / len / size / is_write  in  AXI_ADDR_W / 8 / 3 / 1  request fields
- req_full  out  1  FIFO holds REQ_DEPTH entries
- req_overflow  out  1  sticky: commit dropped
- req_ovf_clr  in  1  clears req_overflow
- dir_alloc_valid  out  1  allocation request
- dir_alloc_entry  out  directory_entry_t  head entry, tag='0
- dir_alloc_ready  in  1  directory accepts
- dir_alloc_tag  in  TAG_W  tag assigned on handshake
- alloc_tag_valid  out  1  one-cycle pulse to regfile
- alloc_tag  out  TAG_W  captured tag
- gw_cpl_valid / gw_cpl_ready  in / out  1  completion handshake
- gw_cpl_data  in  COMPLETION_W  packed completion
- dir_cpl_valid / dir_cpl_ready  out / in  1  directory completion handshake
- rd_status_valid / rd_status_ready  out / in  1  regfile completion handshake
- dir_cpl_{tag,is_write,error,resp,num_beats}, rd_status_{same}  out  TAG_W/1/1/2/8  held completion fields
- dir_cons_valid  in  1  regfile consumed a tag
- dir_cons_tag  in  TAG_W  consumed tag (informational)
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  allocated-not-consumed count

## Operation
- Push on commit_pulse && !req_full. Fullness comes from the registered count, so a commit while full is dropped even if a pop occurs the same cycle.
- A dropped commit sets req_overflow. Set wins over a same-cycle req_ovf_clr.
- FIFO pointers wrap modulo REQ_DEPTH. Simultaneous push and pop leaves the count unchanged.
- dir_alloc_valid = !empty && outstanding < MAX_OUTSTANDING. The head entry is stable while valid is high.
- Pop on dir_alloc_valid && dir_alloc_ready. On that handshake, dir_alloc_tag is registered into alloc_tag and alloc_tag_valid pulses.
- outstanding: +1 on alloc handshake, −1 on dir_cons_valid. Both in the same cycle leaves it unchanged. A consume at 0 is ignored.
- Completion slice FSM, two states:
  - EMPTY: gw_cpl_valid && gw_cpl_ready captures gw_cpl_data, clears dir_sent/rd_sent, and moves to HELD.
  - HELD: dir_cpl_valid = !dir_sent; rd_status_valid = !rd_sent. Each destination's flag sets on its own handshake.
- done = (dir_sent | dir handshake) & (rd_sent | rd handshake).
- gw_cpl_ready = EMPTY | done. When HELD and done and no new capture, return to EMPTY. When HELD and done with a new capture, reload and stay HELD.
- Error fields are passed unmodified.

## Timing
- On reset, all outputs are 0 and the FSM is EMPTY.
- Reset mid-transaction discards FIFO contents and any held completion, and zeroes outstanding and the stats.
- Commit at cycle N gives dir_alloc_valid at N+1. There is no bypass.
- Alloc handshake at N gives alloc_tag_valid high for cycle N+1 only.
- Completion accepted at N gives dir_cpl_valid and rd_status_valid at N+1.
- With both destinations ready, completion throughput is one per cycle.
- gw_cpl_ready has a combinational path from dir_cpl_ready and rd_status_ready.

## Configuration
- APB2AXI_GW_STATS_EN defined:
  - adds outputs stat_alloc_cnt, stat_cpl_cnt, stat_err_cnt (STAT_W each);
  - counters count alloc handshakes, captured completions, and captured completions with error=1;
  - counters saturate at all-ones and clear only on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- apb2axi_pkg adds:
  - gw_cpl_state_e {GW_CPL_EMPTY, GW_CPL_HELD};
  - GW_REQ_DEPTH_DEF = 4.
- directory_entry_t and completion_entry_t are reused from the package.
- Sub-module apb2axi_gw_req_fifo: a synchronous FIFO with push, pop, full, empty and head outputs.

## Test plan
- Reset, then 5 back-to-back commits with dir_alloc_ready=0 and REQ_DEPTH=4 → req_full at cycle 4 after the 4th commit, 5th commit dropped, req_overflow=1; req_ovf_clr then clears it.
- Commit addr=0x1000, len=3; dir_alloc_ready=1, dir_alloc_tag=5 → handshake one cycle after the commit, alloc_tag_valid pulse with alloc_tag=5, outstanding=1.
- MAX_OUTSTANDING=2 with 3 queued commits → dir_alloc_valid low after 2 allocations; one dir_cons_valid → 3rd allocation next cycle, outstanding returns to 2.
- Completion tag=3 with rd_status_ready=0 for 3 cycles and dir_cpl_ready=1 → dir_cpl_valid for 1 cycle only, rd_status_valid held 3 cycles, gw_cpl_ready low until the rd handshake.
- 8 consecutive completions with both ready=1 → 8 delivered in 8 cycles, order preserved, error=1 entry counted in stat_err_cnt (STATS_EN).
- Reset asserted while a completion is HELD and the FIFO holds 2 entries → all valids 0 and outstanding 0 the next cycle.
